pipelined_adder: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshakes. It is the next-generation replacement for the fixed 32-bit ripple adder in the ALU adder path. Operands are split into `STAGES` equal slices, and one slice is added per pipeline stage, so the carry chain per cycle is `WIDTH/STAGES` bits. Results carry sum, carry-out and signed-overflow flags.

---
 rtl/adder_pkg.sv | 19 +
 rtl/adder_slice.sv | 12 +
 rtl/pipelined_adder.sv | 118 +++++++++++
 tb/tb_pipelined_adder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the sliced pipelined adder.
package adder_pkg;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;
  localparam int MAX_W      = 128;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Returned in a MAX_W container; callers keep the low WIDTH bits.
  function automatic logic [MAX_W-1:0] signed_max(input int width);
    return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] signed_min(input int width);
    return MAX_W'(1) << (width - 1);
  endfunction
endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit adder slice with carry in/out.
module adder_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] b_i,
  input  logic          c_i,
  output logic [SW-1:0] s_o,
  output logic          c_o
);
  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{SW{1'b0}}, c_i};
endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/sub: one SW-bit slice per stage, valid/ready with global stall.
// Define PIPELINED_ADDER_SAT_EN to clamp overflowed results to the signed limit.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int SW = slice_w(WIDTH, STAGES);

  logic [STAGES-1:0] vld_pipe;
  logic              stall;
  logic [WIDTH-1:0]  b_eff;
  logic              c_eff;

  assign b_eff     = sub ? ~b : b;
  assign c_eff     = sub | c_in;
  assign out_valid = vld_pipe[STAGES-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

  // Stage k consumes operand slice k; the slices above it ride along in a
  // shrinking skew register, the finished slices below it in a growing sum.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int RW = (STAGES - 1 - k) * SW;
    localparam int DW = (k + 1) * SW;

    logic [RW+SW-1:0] a_in, b_in;
    logic             cin_s, vin;
    logic [SW-1:0]    s_s;
    logic             co_s;
    logic [DW-1:0]    raw_d, sum_d, sum_q;
    logic             c_q;

    if (k == 0) begin : g_head
      assign a_in  = a;
      assign b_in  = b_eff;
      assign cin_s = c_eff;
      assign vin   = in_valid;
      assign raw_d = s_s;
    end else begin : g_head
      assign a_in  = g_st[k-1].g_skew.a_q;
      assign b_in  = g_st[k-1].g_skew.b_q;
      assign cin_s = g_st[k-1].c_q;
      assign vin   = vld_pipe[k-1];
      assign raw_d = {s_s, g_st[k-1].sum_q};
    end

    adder_slice #(.SW(SW)) u_slice (
      .a_i (a_in[SW-1:0]),
      .b_i (b_in[SW-1:0]),
      .c_i (cin_s),
      .s_o (s_s),
      .c_o (co_s)
    );

    if (k < STAGES - 1) begin : g_skew
      logic [RW-1:0] a_q, b_q;
      assign sum_d = raw_d;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_in[RW+SW-1:SW];
          b_q <= b_in[RW+SW-1:SW];
        end
      end
    end else begin : g_tail
      logic ovf_d, ovf_q;
      // Only the top slice sees the operand sign bits, so overflow is decided here.
      assign ovf_d = (a_in[SW-1] == b_in[SW-1]) && (s_s[SW-1] != a_in[SW-1]);
`ifdef PIPELINED_ADDER_SAT_EN
      localparam logic [MAX_W-1:0] SMAX_W = signed_max(WIDTH);
      localparam logic [MAX_W-1:0] SMIN_W = signed_min(WIDTH);
      localparam logic [WIDTH-1:0] SMAX   = SMAX_W[WIDTH-1:0];
      localparam logic [WIDTH-1:0] SMIN   = SMIN_W[WIDTH-1:0];
      assign sum_d = ovf_d ? (a_in[SW-1] ? SMIN : SMAX) : raw_d;
`else
      assign sum_d = raw_d;
`endif
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         ovf_q <= 1'b0;
        else if (!stall) ovf_q <= ovf_d;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_pipe[k] <= 1'b0;
        sum_q       <= '0;
        c_q         <= 1'b0;
      end else if (!stall) begin
        vld_pipe[k] <= vin;
        sum_q       <= sum_d;
        c_q         <= co_s;
      end
    end
  end

  assign sum   = g_st[STAGES-1].sum_q;
  assign c_out = g_st[STAGES-1].c_q;
  assign ovf   = g_st[STAGES-1].g_tail.ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: driver pushes expectations, monitor pops on output.
module tb_pipelined_adder;
  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic              clk = 1'b0;
  logic              rst, in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf;
  logic [WIDTH-1:0]  a, b, sum;

  typedef struct packed {
    logic [31:0] sum;
    logic        c;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat, wn, seen;
  bit   done;
  logic        prev_stall;
  logic [33:0] prev_v;
  exp_t        me;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                 input logic cv, input logic sv);
    exp_t            e;
    logic [31:0]     be;
    longint          ce, sg;
    longint unsigned u;
    be = sv ? ~bv : bv;
    ce = (sv || cv) ? 64'sd1 : 64'sd0;
    u  = {32'd0, av} + {32'd0, be} + 64'(ce);
    sg = longint'($signed(av)) + longint'($signed(be)) + ce;
    e.sum = u[31:0];
    e.c   = u[32];
    e.ovf = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
`ifdef PIPELINED_ADDER_SAT_EN
    if (e.ovf) e.sum = (sg < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic send(input logic [31:0] ta, input logic [31:0] tbv,
                      input logic tc, input logic ts, input exp_t e);
    int n;
    @(negedge clk);
    a = ta; b = tbv; c_in = tc; sub = ts; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("accept", 64'(in_ready), 64'd1);
    if (in_ready) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [31:0] ra, rb;
    logic        rc, rs;
    ra = pick(); rb = pick();
    rc = 1'($urandom_range(1)); rs = 1'($urandom_range(1));
    send(ra, rb, rc, rs, model(ra, rb, rc, rs));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: hold checks while stalled, ready rule, and scoreboard pops.
  initial begin
    prev_stall = 1'b0;
    prev_v     = '0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_data", 64'({sum, c_out, ovf}), 64'(prev_v));
        end
        chk("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: got sum %h, want no output", sum);
          end else begin
            me = sb.pop_front();
            chk("sum", 64'(sum), 64'(me.sum));
            chk("c_out", 64'(c_out), 64'(me.c));
            chk("ovf", 64'(ovf), 64'(me.ovf));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_v     = {sum, c_out, ovf};
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_c_out", 64'(c_out), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Directed corner cases, first one also measures latency.
    send(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, exp_t'{32'hFFFF_FFFF, 1'b0, 1'b0});
    lat = 0;
    do begin
      @(negedge clk); #1;
      lat++;
    end while (!out_valid && lat < 20);
    chk("latency", 64'(lat), 64'(STAGES));
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, exp_t'{32'hFFFF_FFFF, 1'b1, 1'b0});
`ifdef PIPELINED_ADDER_SAT_EN
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, exp_t'{32'h8000_0000, 1'b1, 1'b1});
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, exp_t'{32'h7FFF_FFFF, 1'b0, 1'b1});
`else
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, exp_t'{32'h0000_0000, 1'b1, 1'b1});
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, exp_t'{32'h8000_0000, 1'b0, 1'b1});
`endif
    send(32'd5, 32'd7, 1'b1, 1'b1, exp_t'{32'hFFFF_FFFE, 1'b0, 1'b0});
    drain();

    // 8 back-to-back beats, out_ready low for 3 cycles after the first result.
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
      end
      begin
        wn = 0;
        while (!out_valid && wn < 50) begin
          @(negedge clk); #1;
          wn++;
        end
        chk("stall_first_out", 64'(out_valid), 64'd1);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random gaps and backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(3) == 0) @(negedge clk);
          send_rand();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          out_ready = ($urandom_range(3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with beats in flight and a stalled result at the output.
    out_ready = 1'b0;
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, model(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0));
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, model(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0));
    send(32'h4000_0000, 32'h0000_0003, 1'b1, 1'b1, model(32'h4000_0000, 32'h0000_0003, 1'b1, 1'b1));
    wn = 0;
    while (!out_valid && wn < 20) begin
      @(negedge clk); #1;
      wn++;
    end
    chk("rst_pre_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_sum", 64'(sum), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (out_valid) seen++;
    end
    chk("no_out_after_rst", 64'(seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
